chunk_add_ctrl: RTL and testbench

- Sequencer that performs a W = n*CHUNKS bit addition by time-multiplexing one external n-bit adder slice (cra/csa/cla family, `cin,a,b -> s,cout` interface).
- Captures wide operands through a valid/ready handshake.
- Drives one n-bit slice per cycle, least significant first, chaining the carry through a register.
- Returns the wide sum, carry-out and signed overflow through a second valid/ready handshake. Sits between the stimulus source and the shared adder instance.

---
 rtl/chunk_add_ctrl_pkg.sv | 22 ++
 rtl/chunk_add_ctrl_if.sv | 42 ++++
 rtl/chunk_add_slice_mux.sv | 30 +++
 rtl/chunk_add_ctrl.sv | 146 ++++++++++++++
 tb/tb_chunk_add_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/chunk_add_ctrl_pkg.sv
// Shared definitions for the chunked-add sequencer: state encoding and
// the helper that sizes the slice index register.
package chunk_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width for a slice counter: ceil(log2(chunks)), never below 1 so
  // that a single-slice configuration still has a legal register.
  function automatic int idx_width(input int chunks);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < chunks) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chunk_add_ctrl_if.sv
// Bundle of the operand handshake, the external adder slice connection and
// the result handshake. The controller takes the slave view; the
// environment (stimulus source, adder slice, consumer) takes the master view.
interface chunk_add_ctrl_if #(
  parameter int n      = 2,
  parameter int CHUNKS = 4
);
  localparam int W = n * CHUNKS;

  // operand side
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  // external adder slice
  logic [n-1:0] add_a;
  logic [n-1:0] add_b;
  logic         add_cin;
  logic [n-1:0] add_s;
  logic         add_cout;
  // result side
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  modport master (
    output in_valid, in_a, in_b, in_cin, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_s, out_cout,
           out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_s, out_cout,
           out_ovf, busy
  );

endinterface

// File: rtl/chunk_add_slice_mux.sv
// Picks the n-bit slice number idx_i out of a W-bit word. Out-of-range
// indices (non power-of-two CHUNKS) yield zero.
module chunk_add_slice_mux #(
  parameter int n      = 2,
  parameter int CHUNKS = 4,
  parameter int IDX_W  = 2
) (
  input  logic [n*CHUNKS-1:0] word_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic [n-1:0]        slice_o
);

  logic [n-1:0] slices [CHUNKS];

  genvar gi;
  generate
    for (gi = 0; gi < CHUNKS; gi++) begin : g_slice
      assign slices[gi] = word_i[gi*n +: n];
    end
  endgenerate

  // one-hot style compare keeps the select free of out-of-range indexing
  always_comb begin
    slice_o = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (idx_i == IDX_W'(i)) slice_o = slices[i];
    end
  end

endmodule

// File: rtl/chunk_add_ctrl.sv
// Wide adder sequencer: captures W-bit operands, feeds one n-bit slice per
// cycle (LSB first) to an external adder, chains the carry in a register and
// presents sum, carry-out and signed overflow on a valid/ready handshake.
module chunk_add_ctrl
  import chunk_add_ctrl_pkg::*;
#(
  parameter int n      = 2,
  parameter int CHUNKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  chunk_add_ctrl_if.slave  bus
);

  localparam int W     = n * CHUNKS;
  localparam int IDX_W = idx_width(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cin_q, cin_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;

  logic [n-1:0]     a_slice;
  logic [n-1:0]     b_slice;

  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic [n-1:0]     add_a;
  logic [n-1:0]     add_b;
  logic             add_cin;

  chunk_add_slice_mux #(.n(n), .CHUNKS(CHUNKS), .IDX_W(IDX_W)) u_mux_a (
    .word_i  (a_q),
    .idx_i   (idx_q),
    .slice_o (a_slice)
  );

  chunk_add_slice_mux #(.n(n), .CHUNKS(CHUNKS), .IDX_W(IDX_W)) u_mux_b (
    .word_i  (b_q),
    .idx_i   (idx_q),
    .slice_o (b_slice)
  );

  // next-state and output decode; adder inputs come only from registers
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cin_d     = cin_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          cin_d   = bus.in_cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        busy    = 1'b1;
        add_a   = a_slice;
        add_b   = b_slice;
        add_cin = (idx_q == '0) ? cin_q : carry_q;
        for (int i = 0; i < CHUNKS; i++) begin
          if (idx_q == IDX_W'(i)) res_d[i*n +: n] = bus.add_s;
        end
        carry_d = bus.add_cout;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            cin_d   = bus.in_cin;
            idx_d   = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cin_q   <= cin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;
  assign bus.add_cin   = add_cin;

  // result outputs hold their values until the next operation overwrites them
  assign bus.out_s    = res_q;
  assign bus.out_cout = carry_q;
  assign bus.out_ovf  = (a_q[W-1] == b_q[W-1]) && (res_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_chunk_add_ctrl.sv
// Directed bench for chunk_add_ctrl with a ripple adder slice in the loop.
module tb_chunk_add_ctrl;

  localparam int N  = 2;
  localparam int CH = 4;
  localparam int W  = N * CH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  chunk_add_ctrl_if #(.n(N), .CHUNKS(CH)) bus ();

  chunk_add_ctrl #(.n(N), .CHUNKS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // external n-bit adder slice
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{N{1'b0}}, bus.add_cin};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // present operands and wait (bounded) until they are taken
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int t;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // wait for out_valid; edges counts the accepting edge as edge 1
  task automatic wait_valid(output int edges, output logic [3:0] seq);
    int k;
    edges = 1;
    k = 0;
    seq = '0;
    while (!bus.out_valid && edges < 50) begin
      if (bus.busy && k < 4) begin
        seq[k] = bus.add_cin;
        k++;
      end
      @(posedge clk); #1;
      edges++;
    end
    if (!bus.out_valid) chk("valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  // one full operation with hand-computed expectations; out_ready must be 1
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] es, input logic ec,
                       input logic eo, input logic [3:0] eseq);
    int edges;
    logic [3:0] seq;
    accept(a, b, cin);
    bus.in_valid = 1'b0;
    wait_valid(edges, seq);
    chk({name, "_latency"}, 32'(edges), 32'(CH + 1));
    chk({name, "_cinseq"}, 32'(seq), 32'(eseq));
    chk({name, "_sum"}, 32'(bus.out_s), 32'(es));
    chk({name, "_cout"}, 32'(bus.out_cout), 32'(ec));
    chk({name, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
    $display("op %s: %02h + %02h + %0d -> s=%02h cout=%0d ovf=%0d edges=%0d cinseq=%b",
             name, a, b, cin, bus.out_s, bus.out_cout, bus.out_ovf, edges, seq);
    @(posedge clk); #1;
    chk({name, "_consumed"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [9:0] exp_q [$];

  initial begin
    int edges;
    logic [3:0] seq;
    logic seen;
    int sent, rcvd, cycles;
    bit taken;
    logic [W-1:0] ra, rb, rs;
    logic rc, rco, rov;
    logic [9:0] e;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_s", 32'(bus.out_s), 32'd0);
    chk("rst_add", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // directed sums
    do_op("carry_mid", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 4'b0110);
    do_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 4'b1110);
    do_op("ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 4'b1110);
    do_op("alt_cin", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 4'b1111);

    // backpressure with next operands already waiting
    bus.out_ready = 1'b0;
    accept(8'h12, 8'h34, 1'b0);
    bus.in_a = 8'h20;
    bus.in_b = 8'h22;
    wait_valid(edges, seq);
    chk("bp_latency", 32'(edges), 32'(CH + 1));
    for (int i = 0; i < 3; i++) begin
      chk("bp_sum_hold", 32'(bus.out_s), 32'h46);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    $display("op bp_first: 12 + 34 -> s=%02h held 3 cycles", bus.out_s);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_busy_next", 32'(bus.busy), 32'd1);
    chk("bp_valid_dropped", 32'(bus.out_valid), 32'd0);
    wait_valid(edges, seq);
    chk("bp_second_sum", 32'(bus.out_s), 32'h42);
    $display("op bp_second: 20 + 22 -> s=%02h edges=%0d", bus.out_s, edges);
    @(posedge clk); #1;

    // reset during RUN at idx=2
    accept(8'h33, 8'h44, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(bus.busy), 32'd1);
    chk("abort_add_a_idx2", 32'(bus.add_a), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_busy_low", 32'(bus.busy), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_add", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
    chk("abort_results", 32'({bus.out_s, bus.out_cout, bus.out_ovf}), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | bus.out_valid;
      @(posedge clk); #1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    $display("op abort: 33 + 44 abandoned by reset");
    do_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 4'b0000);

    // randomized back-to-back stream with random out_ready
    sent = 0;
    rcvd = 0;
    cycles = 0;
    bus.in_a = 8'($urandom);
    bus.in_b = 8'($urandom);
    bus.in_cin = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1;
    while (rcvd < 200 && cycles < 20000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      taken = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        ra = bus.in_a;
        rb = bus.in_b;
        {rc, rs} = {1'b0, ra} + {1'b0, rb} + {8'd0, bus.in_cin};
        rov = (ra[7] == rb[7]) && (rs[7] != ra[7]);
        exp_q.push_back({rov, rc, rs});
        taken = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          rco = bus.out_cout;
          chk("stream_result", 32'({bus.out_ovf, rco, bus.out_s}), 32'(e));
          $display("op stream %0d: s=%02h cout=%0d ovf=%0d", rcvd, bus.out_s, rco, bus.out_ovf);
        end
        rcvd++;
      end
      @(posedge clk); #1;
      cycles++;
      if (taken) begin
        sent++;
        if (sent < 200) begin
          bus.in_a = 8'($urandom);
          bus.in_b = 8'($urandom);
          bus.in_cin = 1'($urandom_range(0, 1));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("stream_received", 32'(rcvd), 32'd200);
    chk("stream_sent", 32'(sent), 32'd200);
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
